// File: rtl/signed_seq_divider_pkg.sv
// Shared types and constants for the signed sequential divider.
package signed_seq_divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Quotient returned when the divisor is zero.
    localparam logic [DEF_WIDTH-1:0] QUOT_DIV_ZERO = {DEF_WIDTH{1'b1}};

    // Most negative operand; its magnitude does not fit a signed WIDTH-bit value.
    localparam logic [DEF_WIDTH-1:0] MIN_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/signed_seq_divider_if.sv
// Start/done handshake and operand/result bundle for the signed divider.
interface signed_seq_divider_if
    import signed_seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/signed_seq_divider_div_sub_stage.sv
// Combinational trial subtractor for one restoring-division step.
// Ripple chain computing minuend + ~subtrahend + 1; the final carry-out is
// high when no borrow occurred, which is directly the next quotient bit.
module div_sub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic b_n;
        logic p;
        assign b_n          = ~subtrahend[i];
        assign p            = minuend[i] ^ b_n;
        assign diff[i]      = p ^ carry[i];
        assign carry[i + 1] = (minuend[i] & b_n) | (carry[i] & p);
    end

    assign no_borrow = carry[W];

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle two's-complement divider using a restoring shift-subtract loop.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; captures operands, magnitudes and signs
//   CALC  | one shift/trial-subtract iteration per cycle, WIDTH cycles
//   FIN   | applies signs, writes results and flags, pulses done
module signed_seq_divider
    import signed_seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signed_seq_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] QUOT_DZ = WIDTH'(QUOT_DIV_ZERO);
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(MIN_NEG);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   prem;       // partial remainder
    logic [WIDTH-1:0] qmag;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dmag;       // divisor magnitude
    logic [WIDTH-1:0] dvd_r;      // original dividend, returned as remainder on divide-by-zero
    logic             neg_q;
    logic             neg_r;
    logic             dz_r;
    logic             ovf_r;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // The top remainder bit is always zero after a restoring step, so the
    // shift discards it and brings in the next dividend bit.
    assign shifted = (prem << 1) | (WIDTH + 1)'(qmag[WIDTH-1]);

    div_sub_stage #(
        .W (WIDTH + 1)
    ) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dmag}),
        .diff       (trial),
        .no_borrow  (no_borrow)
    );

    // Sequencer: operand capture, iteration loop and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            prem            <= '0;
            qmag            <= '0;
            dmag            <= '0;
            dvd_r           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz_r            <= 1'b0;
            ovf_r           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd_r    <= bus.dividend;
                        qmag     <= dvd_mag;
                        dmag     <= dvs_mag;
                        prem     <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r    <= bus.dividend[WIDTH-1];
                        dz_r     <= (bus.divisor == '0);
                        ovf_r    <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                        bus.busy <= 1'b1;
                        state    <= (bus.divisor == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    prem <= no_borrow ? trial : shifted;
                    qmag <= {qmag[WIDTH-2:0], no_borrow};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (dz_r) begin
                        bus.quotient  <= QUOT_DZ;
                        bus.remainder <= dvd_r;
                    end else begin
                        // -2^(WIDTH-1) / -1 leaves magnitude 2^(WIDTH-1) unnegated,
                        // which already reads back as MIN_VAL.
                        bus.quotient  <= neg_q ? -qmag : qmag;
                        bus.remainder <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                    end
                    bus.div_by_zero <= dz_r;
                    bus.overflow    <= ovf_r & ~dz_r;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed vector bench for signed_seq_divider.
module tb_signed_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    signed_seq_divider_if #(.WIDTH(8)) bus ();

    signed_seq_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges after the accept edge until done is seen; busy must stay high before it.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic dz, input logic ov, input int lat_exp,
                                input int lat, input logic busy_ok);
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " quotient"}, {24'd0, bus.quotient}, {24'd0, q});
        check({tag, " remainder"}, {24'd0, bus.remainder}, {24'd0, r});
        check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, dz});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, ov});
    endtask

    initial begin
        int         lat;
        logic       busy_ok;
        logic       seen;

        vecs[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9};  //  100 / 7
        vecs[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9};  // -100 / 7
        vecs[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9};  //  100 / -7
        vecs[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 9};  // -100 / -7
        vecs[4]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9};  // -128 / -1
        vecs[5]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9};  // -128 / 1
        vecs[6]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1};  //    5 / 0
        vecs[7]  = '{8'h09, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 9};  //    9 / 3
        vecs[8]  = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9};  //   -7 / 2
        vecs[9]  = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 9};  //  127 / -128
        vecs[10] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 9};  // -128 / -128
        vecs[11] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1};  //   -1 / 0
        vecs[12] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 9};  //  127 / 127

        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        rst_n        = 1'b0;
        #12;
        check("reset outputs",
              {8'd0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].dvd, vecs[i].dvs);
            wait_done(lat, busy_ok);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov,
                         vecs[i].lat, lat, busy_ok);
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), {31'd0, bus.done}, 32'd0);
        end

        // start pulsed mid-CALC with other operands is ignored
        launch(8'h64, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'h01;
        bus.divisor  = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check_result("ignored_start", 8'h0E, 8'h02, 1'b0, 1'b0, 5, lat, busy_ok);

        // start held high across done launches the next division at once
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'h64;
        bus.divisor  = 8'h07;
        @(posedge clk);
        #1;
        bus.dividend = 8'h09;
        bus.divisor  = 8'h03;
        wait_done(lat, busy_ok);
        check_result("held_first", 8'h0E, 8'h02, 1'b0, 1'b0, 9, lat, busy_ok);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check_result("held_second", 8'h03, 8'h00, 1'b0, 1'b0, 9, lat, busy_ok);

        // reset during iteration 4 aborts with no done
        launch(8'h64, 8'h07);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort outputs",
              {8'd0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort no_done", {31'd0, seen}, 32'd0);

        launch(8'h7F, 8'h7F);
        wait_done(lat, busy_ok);
        check_result("after_reset", 8'h01, 8'h00, 1'b0, 1'b0, 9, lat, busy_ok);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
